bean_io_ports: RTL
==================

BEAN_IO_PORTS -- requirements
Module: bean_io_ports

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per IO port.
REQ-002 Parameter NUM_PORTS, default 3: number of IO ports, legal range 1..8.
REQ-003 Parameter SYNC_STAGES, default 2: input synchronizer depth, legal range 2..4.
REQ-004 Port ref_clk, input, 1: the block's single clock; all state on rising edge.
REQ-005 Port chip_rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port bus_addr, input, 6: [5:3] port index, [2:0] register select.
REQ-007 Port bus_wr_en, input, 1: write strobe, one transfer per cycle.
REQ-008 Port bus_rd_en, input, 1: read strobe.
REQ-009 Port bus_wr_data, input, DATA_WIDTH: write data.
REQ-010 Port bus_rd_data, output, DATA_WIDTH: read data.
REQ-011 Port bus_rd_valid, output, 1: read data valid.
REQ-012 Port pad_in, input, NUM_PORTS*DATA_WIDTH: asynchronous pad inputs, port p at [p*DATA_WIDTH +: DATA_WIDTH].
REQ-013 Port pad_out, output, NUM_PORTS*DATA_WIDTH: pad output values.
REQ-014 Port pad_oe, output, NUM_PORTS*DATA_WIDTH: per-bit output enable, 1 = drive.
REQ-015 Port io_clk, input, NUM_PORTS: asynchronous per-port external capture strobe.
REQ-016 Port irq, output, 1: level interrupt.

Function
REQ-017 Register map per port: 0 OUT (RW), 1 DIR (RW, 1 = output), 2 IN (RO), 3 CTRL (RW; bit0 LATCH_EN, other bits read 0), 4 FLAG (W1C), 5 MASK (RW).
REQ-018 pad_out SHALL equal OUT and pad_oe SHALL equal DIR, registered, updating the cycle after the write.
REQ-019 pad_in and io_clk SHALL each pass through SYNC_STAGES flops before any use.
REQ-020 LATCH_EN=0: IN SHALL load the synchronized pad value every cycle.
REQ-021 LATCH_EN=1: IN SHALL load the synchronized pad value only in the cycle after a detected rising edge of the synchronized io_clk[p]; otherwise it holds.
REQ-022 FLAG bit SHALL set in the cycle IN bit changes value; it stays set until a write of 1 to that bit.
REQ-023 A hardware set and a W1C of the same FLAG bit in the same cycle: set SHALL win.
REQ-024 irq SHALL be the registered OR over all ports of (FLAG & MASK); latency one cycle after a FLAG/MASK update.
REQ-025 Read latency: bus_rd_valid SHALL assert exactly one cycle after bus_rd_en, with bus_rd_data valid in that cycle; otherwise bus_rd_valid=0 and bus_rd_data=0.
REQ-026 Port index >= NUM_PORTS or register select 6..7: writes ignored; reads return 0 with bus_rd_valid=1.
REQ-027 Writes to IN SHALL be ignored.
REQ-028 Simultaneous bus_wr_en and bus_rd_en to the same register: read returns the pre-write value.
REQ-029 Pin bits with DIR=1 SHALL still be sampled into IN (read-back of the driven level).

Reset
REQ-030 chip_rst asserted: OUT, DIR, CTRL, FLAG, MASK, IN, all synchronizer flops, irq, bus_rd_valid, and bus_rd_data clear to 0 immediately, without waiting for ref_clk.
REQ-031 Reset mid-operation SHALL discard any pending read; no FLAG bits are set by the release-from-reset synchronizer fill.

Structure
REQ-032 Register-select offsets and CTRL bit positions SHALL reside in shared package bean_io_pkg.
REQ-033 One sub-module, bean_io_sync (SYNC_STAGES synchronizer and rising-edge detect, parametrised width), SHALL be instantiated per port for pad_in and io_clk.

Verification
REQ-034 Write DIR[0]=0xFF, OUT[0]=0x81 -> pad_oe[7:0]=0xFF, pad_out[7:0]=0x81 on the cycle after the second write.
REQ-035 LATCH_EN=0, pad_in port 1 0x00->0x3C -> IN[1]=0x3C after SYNC_STAGES+1 cycles; FLAG[1]=0x3C.
REQ-036 Port 2 LATCH_EN=1, pad_in=0x55, no io_clk edge -> IN[2] holds 0x00; one io_clk[2] pulse -> IN[2]=0x55.
REQ-037 MASK[1]=0x04, FLAG[1]=0x3C -> irq=1; W1C 0x04 -> irq=0 next cycle; W1C in the same cycle as a new bit-2 change -> FLAG bit 2 stays 1.
REQ-038 Read port index 5 with NUM_PORTS=3 -> bus_rd_valid=1, bus_rd_data=0x00; write there changes no state.
REQ-039 Assert chip_rst between ref_clk edges with OUT=0x81 -> pad_out=0x00 and irq=0 before the next edge.

Source files
------------

// File: rtl/bean_io_pkg.sv
// Shared register map and control-bit positions for the bean IO port block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bean_io_pkg;

   // Register select within one port (bus_addr[2:0])
   typedef enum logic [2:0] {
      REG_OUT  = 3'd0,
      REG_DIR  = 3'd1,
      REG_IN   = 3'd2,
      REG_CTRL = 3'd3,
      REG_FLAG = 3'd4,
      REG_MASK = 3'd5
   } reg_sel_e;

   // CTRL register bit positions
   localparam int CTRL_LATCH_EN = 0;

endpackage

// File: rtl/bean_io_sync.sv
// Multi-flop synchronizer for asynchronous inputs with rising-edge detect on the synchronized value.
// Latency: STAGES ref_clk cycles to sync; rise is combinational from the last stage and one extra flop.
// Backpressure: none; samples every cycle.
module bean_io_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise
);

   logic [STAGES-1:0][WIDTH-1:0] stage;
   logic [WIDTH-1:0]             prev;

   // Shift the raw input through the synchronizer chain and keep the previous synchronized value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage <= '0;
         prev  <= '0;
      end else begin
         stage <= {stage[STAGES-2:0], din};
         prev  <= stage[STAGES-1];
      end
   end

   assign sync = stage[STAGES-1];
   assign rise = stage[STAGES-1] & ~prev;

endmodule

// File: rtl/bean_io_ports.sv
// Bus-mapped bank of GPIO ports with synchronized inputs, optional strobe-latched capture, sticky change flags and a level irq.
// Latency: writes visible on pads the cycle after; reads return one cycle after bus_rd_en; irq one cycle after FLAG/MASK change.
// Backpressure: none; one bus transfer accepted every cycle, reads always complete.
module bean_io_ports
   import bean_io_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_PORTS   = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic                            ref_clk,
   input  logic                            chip_rst,
   input  logic [5:0]                      bus_addr,
   input  logic                            bus_wr_en,
   input  logic                            bus_rd_en,
   input  logic [DATA_WIDTH-1:0]           bus_wr_data,
   output logic [DATA_WIDTH-1:0]           bus_rd_data,
   output logic                            bus_rd_valid,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] pad_in,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] pad_out,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] pad_oe,
   input  logic [NUM_PORTS-1:0]            io_clk,
   output logic                            irq
);

   // Cycles after reset during which IN takes up the freshly filled synchronizer value without flagging it
   localparam logic [2:0] PRIME_CYCLES = 3'(SYNC_STAGES + 1);

   logic [2:0] port_idx;
   logic [2:0] reg_sel;
   logic [2:0] prime_cnt;
   logic       primed;

   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_rd;
   logic [NUM_PORTS-1:0]                 port_irq;
   logic [DATA_WIDTH-1:0]                rd_mux;

   assign port_idx = bus_addr[5:3];
   assign reg_sel  = bus_addr[2:0];
   assign primed   = (prime_cnt == PRIME_CYCLES);

   // Count out the synchronizer fill after reset so it cannot raise flags or latch strobes
   always_ff @(posedge ref_clk or posedge chip_rst) begin
      if (chip_rst) begin
         prime_cnt <= '0;
      end else if (!primed) begin
         prime_cnt <= prime_cnt + 3'd1;
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic                  hit;
      logic                  wr;
      logic [DATA_WIDTH-1:0] pad_sync;
      logic [DATA_WIDTH-1:0] pad_rise_unused;
      logic                  strobe_sync_unused;
      logic                  strobe_rise;
      logic [DATA_WIDTH-1:0] out_r;
      logic [DATA_WIDTH-1:0] dir_r;
      logic [DATA_WIDTH-1:0] in_r;
      logic [DATA_WIDTH-1:0] flag_r;
      logic [DATA_WIDTH-1:0] mask_r;
      logic                  ctrl_r;
      logic                  latch_pulse;
      logic [DATA_WIDTH-1:0] in_next;
      logic [DATA_WIDTH-1:0] flag_set;
      logic [DATA_WIDTH-1:0] flag_clr;
      logic [DATA_WIDTH-1:0] rd_val;

      assign hit = (port_idx == 3'(p));
      assign wr  = bus_wr_en && hit;

      bean_io_sync #(
         .WIDTH  (DATA_WIDTH),
         .STAGES (SYNC_STAGES)
      ) u_pad_sync (
         .clk  (ref_clk),
         .rst  (chip_rst),
         .din  (pad_in[p*DATA_WIDTH +: DATA_WIDTH]),
         .sync (pad_sync),
         .rise (pad_rise_unused)
      );

      bean_io_sync #(
         .WIDTH  (1),
         .STAGES (SYNC_STAGES)
      ) u_strobe_sync (
         .clk  (ref_clk),
         .rst  (chip_rst),
         .din  (io_clk[p]),
         .sync (strobe_sync_unused),
         .rise (strobe_rise)
      );

      // Free-running capture when LATCH_EN is clear, otherwise only right after a strobe edge
      assign in_next  = (!ctrl_r || latch_pulse) ? pad_sync : in_r;
      assign flag_set = primed ? (in_next ^ in_r) : '0;
      assign flag_clr = (wr && reg_sel == REG_FLAG) ? bus_wr_data : '0;

      // Bus-writable registers, input capture and sticky change flags (hardware set beats W1C)
      always_ff @(posedge ref_clk or posedge chip_rst) begin
         if (chip_rst) begin
            out_r       <= '0;
            dir_r       <= '0;
            in_r        <= '0;
            flag_r      <= '0;
            mask_r      <= '0;
            ctrl_r      <= 1'b0;
            latch_pulse <= 1'b0;
         end else begin
            in_r        <= in_next;
            latch_pulse <= strobe_rise && primed;
            flag_r      <= (flag_r & ~flag_clr) | flag_set;
            if (wr) begin
               case (reg_sel)
                  REG_OUT:  out_r  <= bus_wr_data;
                  REG_DIR:  dir_r  <= bus_wr_data;
                  REG_CTRL: ctrl_r <= bus_wr_data[CTRL_LATCH_EN];
                  REG_MASK: mask_r <= bus_wr_data;
                  default:  ;
               endcase
            end
         end
      end

      // Read-back value of the selected register within this port
      always_comb begin
         rd_val = '0;
         case (reg_sel)
            REG_OUT:  rd_val = out_r;
            REG_DIR:  rd_val = dir_r;
            REG_IN:   rd_val = in_r;
            REG_CTRL: rd_val[CTRL_LATCH_EN] = ctrl_r;
            REG_FLAG: rd_val = flag_r;
            REG_MASK: rd_val = mask_r;
            default:  rd_val = '0;
         endcase
      end

      assign port_rd[p]                            = rd_val;
      assign port_irq[p]                           = |(flag_r & mask_r);
      assign pad_out[p*DATA_WIDTH +: DATA_WIDTH]   = out_r;
      assign pad_oe[p*DATA_WIDTH +: DATA_WIDTH]    = dir_r;
   end

   // Port select for reads; out-of-range ports read as zero
   always_comb begin
      rd_mux = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (port_idx == 3'(p)) begin
            rd_mux = port_rd[p];
         end
      end
   end

   // One-cycle read response; data is forced to zero whenever no read is returning
   always_ff @(posedge ref_clk or posedge chip_rst) begin
      if (chip_rst) begin
         bus_rd_valid <= 1'b0;
         bus_rd_data  <= '0;
      end else begin
         bus_rd_valid <= bus_rd_en;
         bus_rd_data  <= bus_rd_en ? rd_mux : '0;
      end
   end

   // Registered interrupt level
   always_ff @(posedge ref_clk or posedge chip_rst) begin
      if (chip_rst) begin
         irq <= 1'b0;
      end else begin
         irq <= |port_irq;
      end
   end

endmodule
